dds_out_arb: RTL and testbench

- Two-requester arbiter that shares one W-bit downstream sample path (DAC or serializer) between two DDS channels.
- Picks a requester, drives the select of the 2-input data mux, and registers the chosen sample.
- Hands the sample downstream with valid/ready and returns a one-cycle ack to the winner.
- Sits between the per-channel DDS sample generators and the output stage.

---
 rtl/dds_pkg.sv | 14 +
 rtl/mux_2.sv | 13 +
 rtl/rr_arb_2.sv | 44 ++++
 rtl/dds_out_arb.sv | 83 ++++++++
 tb/tb_dds_out_arb.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS output path.
package dds_pkg;

    localparam int unsigned DDS_SAMPLE_W = 12;
    localparam int unsigned BURST_CNT_W  = 4;

    typedef logic ch_idx_t;

    typedef enum logic [0:0] {
        StEmpty,
        StFull
    } slot_state_e;

endpackage

// File: rtl/mux_2.sv
// Generic two-input data mux.
module mux_2 #(
    parameter int unsigned W = 1
) (
    input  logic [W-1:0] in0_i,
    input  logic [W-1:0] in1_i,
    input  logic         sel_i,
    output logic [W-1:0] out_o
);

    assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/rr_arb_2.sv
// Two-way arbiter with a bounded burst allowance for the last winner.
module rr_arb_2
    import dds_pkg::*;
#(
    parameter int unsigned BURST = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       capture_i,
    output ch_idx_t    grant_o
);

    localparam logic [BURST_CNT_W-1:0] BurstMax = BURST_CNT_W'(BURST);

    ch_idx_t                last_q;
    logic [BURST_CNT_W-1:0] cnt_q;
    logic                   keep_last;

    // cnt_q == 0 only straight after reset: nothing to keep yet, so the non-last side wins.
    assign keep_last = (cnt_q != '0) && (cnt_q < BurstMax);

    always_comb begin
        grant_o = req_i[1];
        if (&req_i) begin
            grant_o = keep_last ? last_q : ~last_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
            cnt_q  <= '0;
        end else if (capture_i) begin
            if (grant_o == last_q) begin
                cnt_q <= (cnt_q >= BurstMax) ? BurstMax : cnt_q + 4'd1;
            end else begin
                cnt_q  <= 4'd1;
                last_q <= grant_o;
            end
        end
    end

endmodule

// File: rtl/dds_out_arb.sv
// Shares one registered sample slot between two DDS channels with valid/ready downstream
// and a one-cycle ack back to the channel whose sample was captured.
module dds_out_arb
    import dds_pkg::*;
#(
    parameter int unsigned W     = DDS_SAMPLE_W,
    parameter int unsigned BURST = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic [W-1:0] data0,
    output logic         ack0,
    input  logic         req1,
    input  logic [W-1:0] data1,
    output logic         ack1,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         sel
);

    slot_state_e  state_q;
    logic [W-1:0] data_q;
    ch_idx_t      sel_q;
    logic [1:0]   ack_q;

    logic [1:0]   elig;
    logic         slot_free;
    logic         capture;
    ch_idx_t      grant;
    logic [W-1:0] mux_out;

    // A req seen while its ack is high is the sample already captured.
    assign elig      = {req1 & ~ack_q[1], req0 & ~ack_q[0]};
    assign slot_free = (state_q == StEmpty) | out_ready;
    assign capture   = slot_free & (|elig);

    rr_arb_2 #(
        .BURST (BURST)
    ) u_arb (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (elig),
        .capture_i (capture),
        .grant_o   (grant)
    );

    mux_2 #(
        .W (W)
    ) u_mux (
        .in0_i (data0),
        .in1_i (data1),
        .sel_i (grant),
        .out_o (mux_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            data_q  <= '0;
            sel_q   <= 1'b0;
            ack_q   <= 2'b00;
        end else begin
            ack_q <= 2'b00;
            if (capture) begin
                state_q <= StFull;
                data_q  <= mux_out;
                sel_q   <= grant;
                ack_q   <= grant ? 2'b10 : 2'b01;
            end else if (slot_free) begin
                state_q <= StEmpty;
            end
        end
    end

    assign out_valid = (state_q == StFull);
    assign out_data  = data_q;
    assign sel       = sel_q;
    assign ack0      = ack_q[0];
    assign ack1      = ack_q[1];

endmodule

// File: tb/tb_dds_out_arb.sv
// Randomised bench: two arbiters (BURST=1 and BURST=3) against a per-cycle behavioural model
// plus an in-order scoreboard of acked samples versus consumed samples.
module tb_dds_out_arb;

    localparam int W = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdy = 1'b0;

    logic         req0_s [2];
    logic         req1_s [2];
    logic [W-1:0] data0_s [2];
    logic [W-1:0] data1_s [2];
    logic         ack0_w [2];
    logic         ack1_w [2];
    logic         valid_w [2];
    logic [W-1:0] odata_w [2];
    logic         sel_w [2];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int           burst_of [2];
    bit           m_valid [2];
    bit           m_ack0 [2];
    bit           m_ack1 [2];
    bit           m_sel [2];
    logic [W-1:0] m_data [2];
    int           m_last [2];
    int           m_cnt [2];

    // Downstream view captured after each edge, consumed at the next one
    bit           sv_valid [2];
    logic [W:0]   sv_word [2];
    logic [W:0]   sb_q0 [$];
    logic [W:0]   sb_q1 [$];

    always #5 clk = ~clk;

    dds_out_arb #(.W(W), .BURST(1)) u_dut_b1 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0_s[0]), .data0(data0_s[0]), .ack0(ack0_w[0]),
        .req1(req1_s[0]), .data1(data1_s[0]), .ack1(ack1_w[0]),
        .out_valid(valid_w[0]), .out_ready(rdy), .out_data(odata_w[0]), .sel(sel_w[0])
    );

    dds_out_arb #(.W(W), .BURST(3)) u_dut_b3 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0_s[1]), .data0(data0_s[1]), .ack0(ack0_w[1]),
        .req1(req1_s[1]), .data1(data1_s[1]), .ack1(ack1_w[1]),
        .out_valid(valid_w[1]), .out_ready(rdy), .out_data(odata_w[1]), .sel(sel_w[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 0; m_ack0[d] = 0; m_ack1[d] = 0; m_sel[d] = 0;
            m_data[d] = '0; m_last[d] = 1; m_cnt[d] = 0;
            sv_valid[d] = 0;
        end
        sb_q0.delete();
        sb_q1.delete();
    endtask

    task automatic sb_push(input int d, input logic [W:0] w);
        if (d == 0) sb_q0.push_back(w);
        else        sb_q1.push_back(w);
    endtask

    task automatic sb_consume(input int d);
        logic [W:0] w;
        int sz;
        sz = (d == 0) ? sb_q0.size() : sb_q1.size();
        check_eq($sformatf("d%0d sb_nonempty", d), sz != 0, 1);
        if (sz != 0) begin
            w = (d == 0) ? sb_q0.pop_front() : sb_q1.pop_front();
            check_eq($sformatf("d%0d sb_order", d), sv_word[d], w);
        end
    endtask

    // One clock edge of the arbiter, straight from the grant/burst rules.
    task automatic model_step();
        bit e0, e1, free;
        int g;
        for (int d = 0; d < 2; d++) begin
            e0   = req0_s[d] && !m_ack0[d];
            e1   = req1_s[d] && !m_ack1[d];
            free = !m_valid[d] || rdy;
            if (free && (e0 || e1)) begin
                if (e0 && e1) begin
                    if (m_cnt[d] == 0 || m_cnt[d] >= burst_of[d]) g = 1 - m_last[d];
                    else g = m_last[d];
                end else begin
                    g = e1 ? 1 : 0;
                end
                if (g == m_last[d]) begin
                    m_cnt[d] = (m_cnt[d] + 1 > burst_of[d]) ? burst_of[d] : m_cnt[d] + 1;
                end else begin
                    m_cnt[d]  = 1;
                    m_last[d] = g;
                end
                m_data[d]  = (g == 1) ? data1_s[d] : data0_s[d];
                m_sel[d]   = (g == 1);
                m_valid[d] = 1;
                m_ack0[d]  = (g == 0);
                m_ack1[d]  = (g == 1);
                sb_push(d, {m_sel[d], m_data[d]});
            end else begin
                m_ack0[d] = 0;
                m_ack1[d] = 0;
                if (free) m_valid[d] = 0;
            end
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d out_valid", d), valid_w[d], m_valid[d]);
            check_eq($sformatf("d%0d out_data", d), odata_w[d], m_data[d]);
            check_eq($sformatf("d%0d sel", d), sel_w[d], m_sel[d]);
            check_eq($sformatf("d%0d ack0", d), ack0_w[d], m_ack0[d]);
            check_eq($sformatf("d%0d ack1", d), ack1_w[d], m_ack1[d]);
            sv_valid[d] = valid_w[d];
            sv_word[d]  = {sel_w[d], odata_w[d]};
        end
    endtask

    task automatic req_step(input bit ack, input int p_new, input int p_keep,
                            input logic r_in, input logic [W-1:0] d_in,
                            output logic r_out, output logic [W-1:0] d_out);
        r_out = r_in;
        d_out = d_in;
        if (r_in && ack) begin
            if ($urandom_range(99) < p_keep) d_out = W'($urandom);
            else r_out = 1'b0;
        end else if (!r_in && $urandom_range(99) < p_new) begin
            r_out = 1'b1;
            d_out = W'($urandom);
        end
    endtask

    task automatic run_cycles(input int n, input int p0, input int p1, input int pk,
                              input int prdy);
        logic r;
        logic [W-1:0] dv;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) if (sv_valid[d] && rdy) sb_consume(d);
            model_step();
            #1;
            compare_all();
            for (int d = 0; d < 2; d++) begin
                req_step(m_ack0[d], p0, pk, req0_s[d], data0_s[d], r, dv);
                req0_s[d] = r; data0_s[d] = dv;
                req_step(m_ack1[d], p1, pk, req1_s[d], data1_s[d], r, dv);
                req1_s[d] = r; data1_s[d] = dv;
            end
            rdy = ($urandom_range(99) < prdy);
        end
    endtask

    // Asynchronous reset mid-stream, both channels left requesting across it.
    task automatic mid_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        for (int d = 0; d < 2; d++) begin
            req0_s[d] = 1'b1; data0_s[d] = W'($urandom);
            req1_s[d] = 1'b1; data1_s[d] = W'($urandom);
        end
        rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        burst_of[0] = 1;
        burst_of[1] = 3;
        for (int d = 0; d < 2; d++) begin
            req0_s[d] = 0; req1_s[d] = 0; data0_s[d] = '0; data1_s[d] = '0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // First capture after reset
        for (int d = 0; d < 2; d++) begin
            req0_s[d] = 1'b1;
            data0_s[d] = 12'h0A5;
        end
        rdy = 1'b1;
        run_cycles(1, 0, 0, 0, 100);
        check_eq("first out_data", odata_w[0], 12'h0A5);
        check_eq("first ack0", ack0_w[1], 1);
        run_cycles(4, 0, 0, 0, 100);

        // Both channels held with fresh data on every ack
        run_cycles(40, 100, 100, 100, 100);
        // Channel 1 alone, then channel 0 joins
        run_cycles(6, 0, 0, 0, 100);
        run_cycles(20, 0, 100, 100, 100);
        run_cycles(10, 100, 100, 100, 100);
        // Downstream stall then release
        run_cycles(10, 100, 0, 100, 100);
        run_cycles(5, 100, 0, 100, 0);
        run_cycles(10, 100, 0, 100, 100);
        // Drop req after each ack: one capture per request
        run_cycles(60, 50, 50, 0, 100);
        // Sparse channel 1 against a busy channel 0 exercises the burst counter
        run_cycles(200, 100, 20, 80, 100);
        run_cycles(300, 60, 60, 60, 60);

        mid_reset();
        run_cycles(1, 100, 100, 100, 100);
        check_eq("reset tie sel d0", sel_w[0], 0);
        check_eq("reset tie sel d1", sel_w[1], 0);
        run_cycles(300, 70, 70, 50, 70);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
